// File: rtl/dataram_access_ctrl.sv
// Data RAM access controller: turns byte, bit, read-modify-write and @Ri
// requests from the execute stage into data RAM chip-select/read-write cycles.
module dataram_access_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [2:0] op,
  input  logic [7:0] req_addr,
  input  logic [1:0] rs,
  input  logic [7:0] wdata,
  input  logic       wbit,
  output logic       busy,
  output logic       ack,
  output logic       err,
  output logic [7:0] rdata,
  output logic       rbit,
  output logic       mem_CS,
  output logic       mem_RW,
  output logic       mem_Bb,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_position,
  output logic [7:0] mem_din,
  output logic       mem_bin,
  input  logic [7:0] mem_dout,
  input  logic       mem_bout
);

  localparam logic [2:0] OP_BRD = 3'b000;
  localparam logic [2:0] OP_BWR = 3'b001;
  localparam logic [2:0] OP_XRD = 3'b010;
  localparam logic [2:0] OP_XWR = 3'b011;
  localparam logic [2:0] OP_SET = 3'b100;
  localparam logic [2:0] OP_CLR = 3'b101;
  localparam logic [2:0] OP_CPL = 3'b110;
  localparam logic [2:0] OP_IND = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_WR   = 3'd3,
    ST_PRD1 = 3'd4,
    ST_PRD2 = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] addr_q;
  logic [1:0] rs_q;
  logic [7:0] wdata_q;
  logic       wbit_q;
  logic [7:0] ptr_q;
  logic [7:0] rdata_q;
  logic       rbit_q;
  logic       err_q;

  logic       accept;
  logic       addr_err;
  logic       is_bit_op;
  logic       is_rmw;
  logic       is_ind;
  logic [7:0] target_addr;
  logic [7:0] ptr_addr;
  logic [7:0] pos_onehot;
  logic       wr_bit;

  assign accept    = (state_q == ST_IDLE) && req;
  assign addr_err  = (op != OP_IND) && req_addr[7];
  assign is_ind    = (op_q == OP_IND);
  assign is_bit_op = (op_q != OP_BRD) && (op_q != OP_BWR) && !is_ind;
  assign is_rmw    = op_q[2] && !is_ind;

  // Bit addresses 0x00-0x7F live in bytes 0x20-0x2F, eight bits per byte.
  assign target_addr = is_ind    ? ptr_q :
                       is_bit_op ? {4'h2, addr_q[6:3]} : addr_q;
  assign ptr_addr    = {3'b000, rs_q, 2'b00, addr_q[0]};

  for (genvar gi = 0; gi < 8; gi++) begin : g_pos
    assign pos_onehot[gi] = (addr_q[2:0] == 3'(gi));
  end

  always_comb begin
    wr_bit = 1'b0;
    case (op_q)
      OP_XWR:  wr_bit = wbit_q;
      OP_SET:  wr_bit = 1'b1;
      OP_CLR:  wr_bit = 1'b0;
      OP_CPL:  wr_bit = ~rbit_q;
      default: wr_bit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (addr_err) begin
            state_d = ST_DONE;
          end else begin
            case (op)
              OP_BWR, OP_XWR: state_d = ST_WR;
              OP_IND:         state_d = ST_PRD1;
              default:        state_d = ST_RD1;
            endcase
          end
        end
      end
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  state_d = is_rmw ? ST_WR : ST_DONE;
      ST_WR:   state_d = ST_DONE;
      ST_PRD1: state_d = ST_PRD2;
      // A pointer outside the RAM aborts before the second access.
      ST_PRD2: state_d = mem_dout[7] ? ST_DONE : ST_RD1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, pointer and result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= OP_BRD;
      addr_q  <= 8'h00;
      rs_q    <= 2'b00;
      wdata_q <= 8'h00;
      wbit_q  <= 1'b0;
      ptr_q   <= 8'h00;
      rdata_q <= 8'h00;
      rbit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op;
        addr_q  <= req_addr;
        rs_q    <= rs;
        wdata_q <= wdata;
        wbit_q  <= wbit;
        err_q   <= addr_err;
      end
      if (state_q == ST_PRD2) begin
        ptr_q <= mem_dout;
        err_q <= mem_dout[7];
      end
      if (state_q == ST_RD2) begin
        if (is_bit_op) rbit_q  <= mem_bout;
        else           rdata_q <= mem_dout;
      end
    end
  end

  // Output logic
  always_comb begin
    busy         = (state_q != ST_IDLE);
    ack          = (state_q == ST_DONE);
    err          = (state_q == ST_DONE) && err_q;
    rdata        = rdata_q;
    rbit         = rbit_q;
    mem_CS       = 1'b1;
    mem_RW       = 1'b1;
    mem_Bb       = 1'b1;
    mem_addr     = 8'h00;
    mem_position = 8'h00;
    mem_din      = 8'h00;
    mem_bin      = 1'b0;
    case (state_q)
      ST_RD1, ST_RD2: begin
        mem_CS       = 1'b0;
        mem_Bb       = ~is_bit_op;
        mem_addr     = target_addr;
        mem_position = is_bit_op ? pos_onehot : 8'h00;
      end
      ST_WR: begin
        mem_CS       = 1'b0;
        mem_RW       = 1'b0;
        mem_Bb       = ~is_bit_op;
        mem_addr     = target_addr;
        mem_position = is_bit_op ? pos_onehot : 8'h00;
        mem_din      = is_bit_op ? 8'h00 : wdata_q;
        mem_bin      = is_bit_op ? wr_bit : 1'b0;
      end
      ST_PRD1, ST_PRD2: begin
        mem_CS   = 1'b0;
        mem_addr = ptr_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dataram_access_ctrl.sv
// Scoreboard bench for dataram_access_ctrl with a behavioural data RAM
// (registered read, write on the edge that ends a write cycle).
module tb_dataram_access_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [2:0] op;
  logic [7:0] req_addr;
  logic [1:0] rs;
  logic [7:0] wdata;
  logic       wbit;
  logic       busy, ack, err, rbit;
  logic [7:0] rdata;
  logic       mem_CS, mem_RW, mem_Bb, mem_bin;
  logic [7:0] mem_addr, mem_position, mem_din;
  logic [7:0] mem_dout;
  logic       mem_bout;

  dataram_access_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .req_addr(req_addr),
    .rs(rs), .wdata(wdata), .wbit(wbit), .busy(busy), .ack(ack), .err(err),
    .rdata(rdata), .rbit(rbit), .mem_CS(mem_CS), .mem_RW(mem_RW),
    .mem_Bb(mem_Bb), .mem_addr(mem_addr), .mem_position(mem_position),
    .mem_din(mem_din), .mem_bin(mem_bin), .mem_dout(mem_dout),
    .mem_bout(mem_bout)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    mem_dout = 8'h00;
    mem_bout = 1'b0;
  end

  always @(posedge clk) begin
    if (!mem_CS) begin
      if (!mem_RW) begin
        if (mem_Bb) ram[mem_addr] <= mem_din;
        else begin
          for (int b = 0; b < 8; b++)
            if (mem_position[b]) ram[mem_addr][b] <= mem_bin;
        end
      end else begin
        mem_dout <= ram[mem_addr];
        mem_bout <= |(ram[mem_addr] & mem_position);
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic       err;
    int         lat;
    int         acc;
    logic       chk_rd;
    logic [7:0] rd;
    logic       chk_rb;
    logic       rb;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic       rw;
    logic       bb;
    logic [7:0] addr;
    logic [7:0] pos;
    logic       bin;
  } bus_t;
  bus_t bus_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
    end
  endtask

  // Bus recorder: one entry per cycle the RAM is selected.
  always @(negedge clk) begin
    if (mem_CS === 1'b0)
      bus_log.push_back('{mem_RW, mem_Bb, mem_addr, mem_position, mem_bin});
  end

  // Monitor: every ack retires the oldest expected response.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      exp_t e;
      ack_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ack: got ack=1, want none at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        $display("txn %s: err=%0b rdata=0x%02h rbit=%0b latency=%0d",
                 e.name, err, rdata, rbit, cyc - e.acc + 1);
        chk({e.name, "_err"}, 32'(err), 32'(e.err));
        chk({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        if (e.chk_rd) chk({e.name, "_rdata"}, 32'(rdata), 32'(e.rd));
        if (e.chk_rb) chk({e.name, "_rbit"}, 32'(rbit), 32'(e.rb));
      end
    end
  end

  task automatic wait_ack(input int start, input string nm);
    int n = 0;
    while (ack_cnt == start && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (ack_cnt == start) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ack in 30 cycles, want ack", nm);
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [1:0] r,
                       input logic [7:0] wd, input logic wb);
    @(negedge clk);
    bus_log.delete();
    op = o; req_addr = a; rs = r; wdata = wd; wbit = wb;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic [2:0] o, input logic [7:0] a,
                       input logic [1:0] r, input logic [7:0] wd, input logic wb,
                       input logic e_err, input int e_lat,
                       input logic c_rd, input logic [7:0] e_rd,
                       input logic c_rb, input logic e_rb);
    int start;
    start = ack_cnt;
    issue(o, a, r, wd, wb);
    exp_q.push_back('{nm, e_err, e_lat, cyc, c_rd, e_rd, c_rb, e_rb});
    wait_ack(start, nm);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_ack"}, 32'(ack), 0);
    chk({nm, "_err"}, 32'(err), 0);
    chk({nm, "_rdata"}, 32'(rdata), 0);
    chk({nm, "_rbit"}, 32'(rbit), 0);
    chk({nm, "_bus"}, {mem_CS, mem_RW, mem_Bb, mem_bin, 28'h0},
        {1'b1, 1'b1, 1'b1, 1'b0, 28'h0});
    chk({nm, "_addrpos"}, {8'h0, mem_addr, mem_position, mem_din}, 32'h0);
  endtask

  initial begin
    int start;
    reset = 1'b0; req = 1'b0; op = 3'b000; req_addr = 8'h00;
    rs = 2'b00; wdata = 8'h00; wbit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b1;

    do_op("bwr_45", 3'b001, 8'h45, 2'd0, 8'hA5, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("brd_45", 3'b000, 8'h45, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'hA5, 1'b0, 1'b0);

    do_op("bset_0B", 3'b100, 8'h0B, 2'd0, 8'h00, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("bset_ncyc", 32'(bus_log.size()), 3);
    if (bus_log.size() == 3) begin
      chk("bset_rd_addr", 32'(bus_log[0].addr), 32'h21);
      chk("bset_rd_pos", 32'(bus_log[0].pos), 32'h08);
      chk("bset_rd_rwbb", {30'h0, bus_log[1].rw, bus_log[1].bb}, 32'h2);
      chk("bset_wr_addr", 32'(bus_log[2].addr), 32'h21);
      chk("bset_wr_pos", 32'(bus_log[2].pos), 32'h08);
      chk("bset_wr_ctl", {29'h0, bus_log[2].rw, bus_log[2].bb, bus_log[2].bin}, 32'h1);
    end
    do_op("brd_21a", 3'b000, 8'h21, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h08, 1'b0, 1'b0);

    do_op("bcpl_1", 3'b110, 8'h0B, 2'd0, 8'h00, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op("brd_21b", 3'b000, 8'h21, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h00, 1'b0, 1'b0);
    do_op("bcpl_2", 3'b110, 8'h0B, 2'd0, 8'h00, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("brd_21c", 3'b000, 8'h21, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h08, 1'b0, 1'b0);

    do_op("xrd_0B", 3'b010, 8'h0B, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op("xwr_0B", 3'b011, 8'h0B, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("xwr_7F", 3'b011, 8'h7F, 2'd0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("brd_2F", 3'b000, 8'h2F, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h80, 1'b0, 1'b0);
    do_op("bclr_7F", 3'b101, 8'h7F, 2'd0, 8'h00, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op("xrd_7F", 3'b010, 8'h7F, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("brd_21d", 3'b000, 8'h21, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h00, 1'b0, 1'b0);

    do_op("bwr_R1", 3'b001, 8'h11, 2'd0, 8'h50, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("bwr_50", 3'b001, 8'h50, 2'd0, 8'h3C, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("ind_ok", 3'b111, 8'h01, 2'd2, 8'h00, 1'b0, 1'b0, 5, 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("ind_ncyc", 32'(bus_log.size()), 4);
    if (bus_log.size() == 4) begin
      chk("ind_ptr_addr", 32'(bus_log[0].addr), 32'h11);
      chk("ind_ptr_bb", 32'(bus_log[1].bb), 1);
      chk("ind_dat_addr", 32'(bus_log[2].addr), 32'h50);
      chk("ind_dat_addr2", 32'(bus_log[3].addr), 32'h50);
    end

    do_op("bwr_R1b", 3'b001, 8'h11, 2'd0, 8'h90, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("ind_err", 3'b111, 8'h01, 2'd2, 8'h00, 1'b0, 1'b1, 3, 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("ind_err_ncyc", 32'(bus_log.size()), 2);

    do_op("bwr_80", 3'b001, 8'h80, 2'd0, 8'h77, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("bwr_80_ncyc", 32'(bus_log.size()), 0);
    chk("bwr_80_ram", 32'(ram[8'h80]), 0);

    // Second request while busy must be dropped.
    start = ack_cnt;
    issue(3'b000, 8'h45, 2'd0, 8'h00, 1'b0);
    exp_q.push_back('{"brd_busy", 1'b0, 3, cyc, 1'b1, 8'hA5, 1'b0, 1'b0});
    @(negedge clk);
    chk("busy_c1", 32'(busy), 1);
    op = 3'b001; req_addr = 8'h45; wdata = 8'h00; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_ack(start, "brd_busy");
    repeat (4) @(negedge clk);
    chk("busy_ack_count", 32'(ack_cnt - start), 1);
    do_op("brd_45b", 3'b000, 8'h45, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'hA5, 1'b0, 1'b0);

    // Reset in the middle of a bit set: the write phase must never happen.
    issue(3'b100, 8'h0B, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst_c3");
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_c4");
    begin
      int nwr = 0;
      foreach (bus_log[i]) if (!bus_log[i].rw) nwr++;
      chk("rst_nowrite", 32'(nwr), 0);
    end
    chk("rst_ram21", 32'(ram[8'h21]), 0);
    do_op("brd_21e", 3'b000, 8'h21, 2'd0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
